elixirchip_es1_spu_op_acc: RTL

Clock-enabled unsigned accumulator for the ES1 SPU datapath. It sits directly downstream of the SPU `nop` delay stage and consumes its aligned `m_data` together with the matching clear/valid qualifiers. It produces a running sum, a sticky overflow flag and a saturating sample count, all delayed by a configurable pipeline latency.

---
 rtl/elixirchip_es1_spu_op_acc.sv | 110 +++++++++++
 1 files changed

// File: rtl/elixirchip_es1_spu_op_acc.sv
// Purpose: clock-enabled unsigned accumulator with sticky overflow and saturating sample count.
// Latency: LATENCY cke-enabled edges from input sample to outputs (1..8); all outputs registered.
// Backpressure: none; one sample accepted per cke-enabled edge, cke=0 freezes every stage.
//
// Ports:
//   reset      async active-low reset; loads CLEAR_DATA / zero into every stage
//   clk        rising-edge clock
//   cke        clock enable for all state
//   s_clear    restart accumulation (ignored when USE_CLEAR=0)
//   s_data     addend
//   s_valid    addend qualifier (forced to 1 when USE_VALID=0)
//   m_data     accumulated sum, delayed by LATENCY
//   m_overflow sticky carry-out since last clear, delayed by LATENCY
//   m_count    valid samples since last clear (saturating), delayed by LATENCY
module elixirchip_es1_spu_op_acc #(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter int    COUNT_BITS = 8,
  parameter data_t CLEAR_DATA = '0,
  parameter bit    USE_CLEAR  = 1'b1,
  parameter bit    USE_VALID  = 1'b1,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic                  s_clear,
  input  data_t                 s_data,
  input  logic                  s_valid,
  output data_t                 m_data,
  output logic                  m_overflow,
  output logic [COUNT_BITS-1:0] m_count
);

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  // Build controls are carried for compatibility with the rest of the SPU
  // library; they select nothing in this generic implementation.
  if (DEVICE == "" && SIMULATION == "" && DEBUG == "") begin : g_build_ctrl
  end

  // Index 0 is the accumulator itself; 1..LATENCY-1 are the delay chain.
  data_t                 acc_q [LATENCY];
  logic                  ovf_q [LATENCY];
  logic [COUNT_BITS-1:0] cnt_q [LATENCY];

  data_t                 acc_d;
  logic                  ovf_d;
  logic [COUNT_BITS-1:0] cnt_d;

  logic                  clr;
  logic                  vld;
  data_t                 base_acc;
  logic                  base_ovf;
  logic [COUNT_BITS-1:0] base_cnt;
  logic [DATA_BITS:0]    sum;

  assign clr = USE_CLEAR ? s_clear : 1'b0;
  assign vld = USE_VALID ? s_valid : 1'b1;

  // A clear rebases the run first, so clear+valid naturally starts a new
  // run that already includes the current sample.
  always_comb begin
    base_acc = acc_q[0];
    base_ovf = ovf_q[0];
    base_cnt = cnt_q[0];
    if (clr) begin
      base_acc = CLEAR_DATA;
      base_ovf = 1'b0;
      base_cnt = '0;
    end

    sum   = {1'b0, base_acc} + {1'b0, s_data};
    acc_d = base_acc;
    ovf_d = base_ovf;
    cnt_d = base_cnt;
    if (vld) begin
      acc_d = sum[DATA_BITS-1:0];
      ovf_d = base_ovf | sum[DATA_BITS];
      cnt_d = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + COUNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        acc_q[i] <= CLEAR_DATA;
        ovf_q[i] <= 1'b0;
        cnt_q[i] <= '0;
      end
    end else if (cke) begin
      acc_q[0] <= acc_d;
      ovf_q[0] <= ovf_d;
      cnt_q[0] <= cnt_d;
      for (int i = 1; i < LATENCY; i++) begin
        acc_q[i] <= acc_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
        cnt_q[i] <= cnt_q[i-1];
      end
    end
  end

  assign m_data     = acc_q[LATENCY-1];
  assign m_overflow = ovf_q[LATENCY-1];
  assign m_count    = cnt_q[LATENCY-1];

endmodule
